aud_recorder: RTL and testbench
===============================

Name: aud_recorder

Overview:
Capture stage between the WM8731 codec ADC and the SRAM. Deserializes the I2S left-channel ADC stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) into 16-bit samples. Each sample is presented as a one-cycle SRAM write request at an incrementing address. It is controlled by the debounced start/pause/stop pulses from the top-level controller and runs on the 12 MHz PLL clock.

Parameters:
ADDR_W, 20, SRAM word-address width.
MAX_ADDR, 20'hFFFFF, last writable address; recording ends after this word is written.

Ports:
clk  input  1  12 MHz system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
i_start  input  1  one-cycle pulse: begin a new recording at address 0.
i_pause  input  1  one-cycle pulse: toggle pause/resume.
i_stop  input  1  one-cycle pulse: end recording.
i_bclk  input  1  codec bit clock (asynchronous to clk, at most clk/4).
i_lrc  input  1  codec ADC LR clock; low = left channel.
i_data  input  1  codec ADC serial data, MSB first.
o_addr  output  ADDR_W  SRAM address of current/next write.
o_data  output  16  sample to write.
o_we  output  1  one-cycle write strobe; o_addr/o_data valid while high.
o_len  output  ADDR_W+1  number of samples written in this recording.
o_busy  output  1  high in any state other than IDLE.
o_paused  output  1  high in PAUSED.
o_full  output  1  set when MAX_ADDR is written; cleared by i_start.

Behaviour:
- Reset value of every output and register is 0; state is IDLE.
- i_bclk, i_lrc and i_data each pass through a 2-FF synchronizer plus one history flop.
- bclk_rise = sync_bclk & ~prev_bclk. lrc_fall = ~sync_lrc & prev_lrc.
- States and transitions:
  - IDLE: on i_start, clear o_addr, o_len and o_full, then go to WAIT_L.
  - WAIT_L: on lrc_fall, go to SKIP.
  - SKIP: consume exactly one bclk_rise (the I2S one-bit delay), then go to SHIFT with bit counter = 0.
  - SHIFT: on each bclk_rise, shift_reg <= {shift_reg[14:0], sync_data} and increment the counter. On the 16th bclk_rise, go to WRITE.
  - WRITE: exactly one clk. o_we = 1 and o_data = shift_reg. On the next clk: o_len += 1. If o_addr == MAX_ADDR, set o_full and go to IDLE with o_addr held. Otherwise o_addr += 1; go to PAUSED if a pause is pending, else WAIT_L.
  - PAUSED: on i_pause, go to WAIT_L. On i_stop, go to IDLE.
- Latency: o_we rises one clk after the clk in which the 16th bclk_rise is detected.
- Right-channel data (lrc high) is ignored.
- i_pause in WAIT_L or SKIP: go to PAUSED immediately. In SHIFT or WRITE: latch pause_pending and finish the current sample first; a second i_pause before the write cancels the pending pause.
- i_stop in any non-IDLE state: go to IDLE next cycle and discard any partial sample. If it coincides with WRITE, the write still completes (o_we stays 1 that cycle) and o_len counts it.
- Simultaneous pulses: i_stop beats i_pause; i_start is ignored unless in IDLE.
- lrc_fall during SHIFT (a frame shorter than 16 bits): discard the partial sample and go to SKIP.
- o_len saturates at 2^ADDR_W and holds its value in IDLE until the next i_start.
- Asserting rst mid-operation returns to IDLE immediately. No o_we glitch on release.

Test Plan:
1. Reset, then i_start; drive one I2S frame with left = 16'hA5C3 and right = 16'h1234 (bclk = clk/4) -> exactly one o_we with o_data = A5C3, o_addr = 0; afterwards o_len = 1, o_addr = 1.
2. Three consecutive frames with left = 0001, 8000, FFFF -> writes at addresses 0, 1, 2 with those values; o_len = 3; right-channel data never written.
3. i_pause at bit 7 of a sample -> that sample still written, then o_paused = 1 and no o_we for 5 frames; i_pause -> capture resumes at the next lrc_fall, next write at the following address.
4. i_stop at bit 9 -> o_busy = 0 within 1 clk, no write for the partial sample, o_len unchanged; then i_start -> o_addr = 0, o_len = 0.
5. MAX_ADDR = 3, four frames -> writes at 0..3, o_full = 1, state IDLE, o_len = 4; a fifth frame produces no o_we.
6. rst low during SHIFT -> all outputs 0; i_stop coincident with o_we -> write completes and o_len increments by 1.

Source files
------------

// File: rtl/aud_recorder.sv
// I2S left-channel capture from the WM8731 ADC into 16-bit samples, issued as
// one-cycle SRAM write requests at incrementing addresses.
module aud_recorder #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_bclk,
    input  logic              i_lrc,
    input  logic              i_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic [15:0]       o_data,
    output logic              o_we,
    output logic [ADDR_W:0]   o_len,
    output logic              o_busy,
    output logic              o_paused,
    output logic              o_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_L,
        S_SKIP,
        S_SHIFT,
        S_WRITE,
        S_PAUSED
    } state_t;

    state_t      state, state_d;
    logic [2:0]  bclk_sr, lrc_sr;
    logic [1:0]  data_sr;
    logic        bclk_rise, lrc_fall, sync_data;
    logic [15:0] shift_reg;
    logic [3:0]  bit_cnt;
    logic        pause_pending, pend_d;
    logic        do_shift;
    logic        at_max;

    // Sample count holds at 2^ADDR_W once the MSB is reached.
    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        if (v[ADDR_W])
            return v;
        return v + (ADDR_W+1)'(1);
    endfunction

    // Codec pins are asynchronous to clk: two sync stages, then a history flop for edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_sr <= '0;
            lrc_sr  <= '0;
            data_sr <= '0;
        end else begin
            bclk_sr <= {bclk_sr[1:0], i_bclk};
            lrc_sr  <= {lrc_sr[1:0], i_lrc};
            data_sr <= {data_sr[0], i_data};
        end
    end

    assign bclk_rise = bclk_sr[1] & ~bclk_sr[2];
    assign lrc_fall  = ~lrc_sr[1] & lrc_sr[2];
    assign sync_data = data_sr[1];
    assign at_max    = (o_addr == MAX_ADDR);

    always_comb begin
        state_d  = state;
        pend_d   = 1'b0;
        do_shift = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start)
                    state_d = S_WAIT_L;
            end
            S_WAIT_L: begin
                if (i_stop)
                    state_d = S_IDLE;
                else if (i_pause)
                    state_d = S_PAUSED;
                else if (lrc_fall)
                    state_d = S_SKIP;
            end
            S_SKIP: begin
                if (i_stop)
                    state_d = S_IDLE;
                else if (i_pause)
                    state_d = S_PAUSED;
                else begin
                    pend_d = pause_pending;
                    if (bclk_rise)
                        state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_stop)
                    state_d = S_IDLE;
                else begin
                    // A pause here only arms; a second pause before the write disarms.
                    pend_d = pause_pending ^ i_pause;
                    if (lrc_fall)
                        state_d = S_SKIP;
                    else if (bclk_rise) begin
                        do_shift = 1'b1;
                        if (bit_cnt == 4'd15)
                            state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (i_stop || at_max)
                    state_d = S_IDLE;
                else if (pause_pending ^ i_pause)
                    state_d = S_PAUSED;
                else
                    state_d = S_WAIT_L;
            end
            S_PAUSED: begin
                if (i_stop)
                    state_d = S_IDLE;
                else if (i_pause)
                    state_d = S_WAIT_L;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            pause_pending <= 1'b0;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            o_addr        <= '0;
            o_len         <= '0;
            o_full        <= 1'b0;
        end else begin
            state         <= state_d;
            pause_pending <= pend_d;
            if (state == S_IDLE && i_start) begin
                o_addr <= '0;
                o_len  <= '0;
                o_full <= 1'b0;
            end
            if (state == S_SKIP && bclk_rise)
                bit_cnt <= '0;
            if (do_shift) begin
                shift_reg <= {shift_reg[14:0], sync_data};
                bit_cnt   <= bit_cnt + 4'd1;
            end
            // The write cycle always commits, even when a stop arrives with it.
            if (state == S_WRITE) begin
                o_len <= sat_inc(o_len);
                if (at_max)
                    o_full <= 1'b1;
                else
                    o_addr <= o_addr + ADDR_W'(1);
            end
        end
    end

    assign o_we     = (state == S_WRITE);
    assign o_data   = shift_reg;
    assign o_busy   = (state != S_IDLE);
    assign o_paused = (state == S_PAUSED);

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: I2S frames driven at bclk = clk/4 into a full-size and
// a MAX_ADDR=3 recorder, checked against a frame-level recording model.
module tb_aud_recorder;

    logic clk = 1'b0;
    logic rst;
    logic i_start, i_pause, i_stop, i_bclk, i_lrc, i_data;

    logic [19:0] addr_a, addr_b;
    logic [15:0] data_a, data_b;
    logic        we_a, we_b;
    logic [20:0] len_a, len_b;
    logic        busy_a, busy_b, paused_a, paused_b, full_a, full_b;

    always #5 clk = ~clk;

    aud_recorder dut_a (
        .clk(clk), .rst(rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .i_bclk(i_bclk), .i_lrc(i_lrc), .i_data(i_data),
        .o_addr(addr_a), .o_data(data_a), .o_we(we_a), .o_len(len_a),
        .o_busy(busy_a), .o_paused(paused_a), .o_full(full_a)
    );

    aud_recorder #(.ADDR_W(20), .MAX_ADDR(20'd3)) dut_b (
        .clk(clk), .rst(rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .i_bclk(i_bclk), .i_lrc(i_lrc), .i_data(i_data),
        .o_addr(addr_b), .o_data(data_b), .o_we(we_b), .o_len(len_b),
        .o_busy(busy_b), .o_paused(paused_b), .o_full(full_b)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed writes, sampled on the falling clk edge.
    logic [35:0] got_a[$], got_b[$];
    always @(negedge clk) begin
        if (we_a) got_a.push_back({addr_a, data_a});
        if (we_b) got_b.push_back({addr_b, data_b});
    end

    // Recording model: one entry per recorder instance.
    localparam int LEN_CAP = 1 << 20;
    logic [35:0] exp_a[$], exp_b[$];
    logic [19:0] m_addr[2];
    logic [19:0] m_max[2];
    int          m_len[2];
    bit          m_full[2], m_rec[2], m_pause[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = '0; m_len[d] = 0; m_full[d] = 0; m_rec[d] = 0; m_pause[d] = 0;
        end
    endtask

    task automatic model_start();
        for (int d = 0; d < 2; d++)
            if (!m_rec[d]) begin
                m_rec[d] = 1; m_pause[d] = 0; m_addr[d] = '0; m_len[d] = 0; m_full[d] = 0;
            end
    endtask

    task automatic model_pause();
        for (int d = 0; d < 2; d++)
            if (m_rec[d]) m_pause[d] = !m_pause[d];
    endtask

    task automatic model_stop();
        for (int d = 0; d < 2; d++) begin
            m_rec[d] = 0; m_pause[d] = 0;
        end
    endtask

    // mid: 0 none, 1 pause during the left word, 2 stop during the left word.
    task automatic model_frame(input logic [15:0] left, input int mid);
        for (int d = 0; d < 2; d++) begin
            if (m_rec[d] && !m_pause[d] && mid != 2) begin
                if (d == 0) exp_a.push_back({m_addr[d], left});
                else        exp_b.push_back({m_addr[d], left});
                if (m_len[d] < LEN_CAP) m_len[d]++;
                if (m_addr[d] == m_max[d]) begin
                    m_full[d] = 1; m_rec[d] = 0;
                end else
                    m_addr[d] = m_addr[d] + 20'd1;
            end
            if (mid == 2) begin
                m_rec[d] = 0; m_pause[d] = 0;
            end else if (mid == 1 && m_rec[d])
                m_pause[d] = !m_pause[d];
        end
    endtask

    task automatic compare_all();
        logic [35:0] g, e;
        check("nwr_a", got_a.size(), exp_a.size());
        while (got_a.size() > 0 && exp_a.size() > 0) begin
            g = got_a.pop_front(); e = exp_a.pop_front(); check("wr_a", g, e);
        end
        got_a.delete(); exp_a.delete();
        check("nwr_b", got_b.size(), exp_b.size());
        while (got_b.size() > 0 && exp_b.size() > 0) begin
            g = got_b.pop_front(); e = exp_b.pop_front(); check("wr_b", g, e);
        end
        got_b.delete(); exp_b.delete();
        check("addr_a", addr_a, m_addr[0]);
        check("len_a", len_a, m_len[0]);
        check("full_a", full_a, m_full[0]);
        check("busy_a", busy_a, m_rec[0]);
        check("paused_a", paused_a, m_pause[0]);
        check("addr_b", addr_b, m_addr[1]);
        check("len_b", len_b, m_len[1]);
        check("full_b", full_b, m_full[1]);
        check("busy_b", busy_b, m_rec[1]);
        check("paused_b", paused_b, m_pause[1]);
    endtask

    // One bclk period (4 clk), entered on a falling clk edge; lrc/data change with bclk fall.
    task automatic bclk_cycle(input logic l, input logic d, input logic [1:0] pulse);
        i_bclk = 1'b0; i_lrc = l; i_data = d;
        if (pulse[0]) i_pause = 1'b1;
        if (pulse[1]) i_stop = 1'b1;
        @(negedge clk);
        if (pulse[0]) i_pause = 1'b0;
        if (pulse[1]) i_stop = 1'b0;
        @(negedge clk);
        i_bclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    logic carry = 1'b0;

    // I2S frame, 16 bclk per channel, MSB one bclk after the LRC edge.
    task automatic send_frame(input logic [15:0] left, input logic [15:0] right,
                              input int mid_kind, input int mid_k);
        logic b;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) b = carry; else b = left[16-k];
            bclk_cycle(1'b0, b, (k == mid_k) ? 2'(mid_kind) : 2'b00);
        end
        for (int k = 0; k < 16; k++) begin
            if (k == 0) b = left[0]; else b = right[16-k];
            bclk_cycle(1'b1, b, 2'b00);
        end
        carry = right[0];
    endtask

    // kind: 0 start, 1 pause, 2 stop
    task automatic pulse_ctl(input int kind);
        if (kind == 0) i_start = 1'b1;
        if (kind == 1) i_pause = 1'b1;
        if (kind == 2) i_stop = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        @(negedge clk);
        if (kind == 0) model_start();
        if (kind == 1) model_pause();
        if (kind == 2) model_stop();
    endtask

    task automatic do_frame(input logic [15:0] left, input logic [15:0] right,
                            input int mid_kind, input int mid_k);
        send_frame(left, right, mid_kind, mid_k);
        model_frame(left, mid_kind);
        @(negedge clk); #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] l, r;
        bit seen;
        int op, mk;
        m_max[0] = 20'hFFFFF;
        m_max[1] = 20'd3;
        model_reset();
        rst = 1'b0;
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        i_bclk = 1'b1; i_lrc = 1'b1; i_data = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", addr_a, 0);
        check("rst_len", len_a, 0);
        check("rst_we", we_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_full", full_a, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame
        pulse_ctl(0);
        do_frame(16'hA5C3, 16'h1234, 0, -1);
        check("t1_len", len_a, 1);
        check("t1_addr", addr_a, 1);

        // Three consecutive frames from a fresh recording
        pulse_ctl(2);
        pulse_ctl(0);
        do_frame(16'h0001, 16'hBEEF, 0, -1);
        do_frame(16'h8000, 16'h7777, 0, -1);
        do_frame(16'hFFFF, 16'h0F0F, 0, -1);
        check("t2_len", len_a, 3);

        // Pause mid-sample: sample kept, then paused for five frames, then resume
        do_frame(16'h1357, 16'h2468, 1, 8);
        check("t3_paused", paused_a, 1);
        for (int i = 0; i < 5; i++) do_frame(16'($urandom), 16'($urandom), 0, -1);
        pulse_ctl(1);
        do_frame(16'hC0DE, 16'h5555, 0, -1);

        // Stop mid-sample, then restart
        fork
            send_frame(16'hDEAD, 16'hAAAA, 2, 10);
            begin
                repeat (41) @(negedge clk);
                #1 check("t4_busy_after_stop", busy_a, 0);
            end
        join
        model_frame(16'hDEAD, 2);
        @(negedge clk); #1;
        compare_all();
        pulse_ctl(0);
        check("t4_addr0", addr_a, 0);
        check("t4_len0", len_a, 0);

        // Small recorder fills at address 3, fifth frame ignored
        for (int i = 0; i < 5; i++) do_frame(16'($urandom), 16'($urandom), 0, -1);
        check("t5_full", full_b, 1);
        check("t5_len", len_b, 4);
        check("t5_busy", busy_b, 0);

        // Reset in the middle of a sample
        fork
            send_frame(16'h4242, 16'h9999, 0, -1);
            begin
                repeat (30) @(negedge clk);
                rst = 1'b0;
                #1;
                check("t6_rst_addr", addr_a, 0);
                check("t6_rst_len", len_a, 0);
                check("t6_rst_data", data_a, 0);
                check("t6_rst_busy", busy_a, 0);
                check("t6_rst_we", we_a, 0);
                @(negedge clk);
                rst = 1'b1;
            end
        join
        model_reset();
        model_frame(16'h4242, 0);
        @(negedge clk); #1;
        compare_all();

        // Stop landing on the write cycle
        pulse_ctl(0);
        do_frame(16'h1111, 16'h2222, 0, -1);
        l = 16'h6A6A;
        seen = 0;
        fork
            send_frame(l, 16'h3333, 0, -1);
            begin
                for (int t = 0; t < 200 && !seen; t++) begin
                    @(negedge clk);
                    if (we_a) begin
                        seen = 1;
                        i_stop = 1'b1;
                        @(negedge clk);
                        i_stop = 1'b0;
                    end
                end
            end
        join
        check("t6_stop_we_seen", seen, 1);
        model_frame(l, 0);
        model_stop();
        @(negedge clk); #1;
        compare_all();
        check("t6_len_after_stop", len_a, 2);

        // Randomized session
        pulse_ctl(0);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 13);
            if (op == 0 || op == 5) pulse_ctl(0);
            else if (op == 1) pulse_ctl(1);
            else if (op == 2) pulse_ctl(2);
            mk = 0;
            if (op == 3) mk = 1;
            if (op == 4) mk = 2;
            l = 16'($urandom);
            r = 16'($urandom);
            do_frame(l, r, mk, $urandom_range(3, 14));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
